hazard_stall_ctrl: RTL and testbench

//  ID-stage stall/bubble controller; counterpart to the ID forwarding unit. Detects hazards forwarding cannot cover
//  (load result still in EXE; data memory not ready) and freezes/bubbles pipeline registers. Also owns the

---
 rtl/hazard_stall_ctrl_pkg.sv | 52 +++++
 rtl/hazard_stall_ctrl_detect.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: stall FSM encoding, sentinel field values
// and the per-cycle pipeline-register control bundle.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_flush;
    } ctrl_t;

    // Whole front end held; only MEM/WB sees a bubble while the memory access is outstanding.
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c             = '0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_load_use();
        ctrl_t c;
        c            = '0;
        c.idex_en    = 1'b1;
        c.idex_flush = 1'b1;
        c.exmem_en   = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_flow(input logic branch_taken);
        ctrl_t c;
        c            = '0;
        c.pc_en      = 1'b1;
        c.ifid_en    = 1'b1;
        c.ifid_flush = branch_taken;
        c.idex_en    = 1'b1;
        c.exmem_en   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_detect.sv
// Combinational hazard detection: load-use against the EXE stage and an outstanding
// data-memory access in MEM. Register 0 is hard-wired and never a hazard source.
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic [4:0] rd_exe,
    input  logic       RegWrite_exe,
    input  logic [2:0] MemRead_exe,
    input  logic [2:0] MemRead_mem,
    input  logic       MemWrite_mem,
    input  logic       dmem_ready,
    output logic       o_load_use,
    output logic       o_mem_busy
);

    logic w_exe_is_load;
    logic w_rs_match;
    logic w_rt_match;
    logic w_mem_access;

    assign w_exe_is_load = (MemRead_exe != MEM_NONE) && RegWrite_exe && (rd_exe != REG_ZERO);
    assign w_rs_match    = use_rs && (rd_exe == rs_id);
    assign w_rt_match    = use_rt && (rd_exe == rt_id);
    assign o_load_use    = w_exe_is_load && (w_rs_match || w_rt_match);

    assign w_mem_access  = (MemRead_mem != MEM_NONE) || MemWrite_mem;
    assign o_mem_busy    = w_mem_access && !dmem_ready;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/bubble controller: load-use stalls, data-memory wait freeze with a
// watchdog that halts the pipeline, taken-branch IF/ID flush and performance counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             branch_taken,
    input  logic [4:0]       rd_exe,
    input  logic             RegWrite_exe,
    input  logic [2:0]       MemRead_exe,
    input  logic [2:0]       MemRead_mem,
    input  logic             MemWrite_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    logic              w_load_use;
    logic              w_mem_busy;
    logic              w_active;
    ctrl_t             w_ctrl;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              r_mem_timeout;

    hazard_detect u_detect (
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .use_rs       (use_rs),
        .use_rt       (use_rt),
        .rd_exe       (rd_exe),
        .RegWrite_exe (RegWrite_exe),
        .MemRead_exe  (MemRead_exe),
        .MemRead_mem  (MemRead_mem),
        .MemWrite_mem (MemWrite_mem),
        .dmem_ready   (dmem_ready),
        .o_load_use   (w_load_use),
        .o_mem_busy   (w_mem_busy)
    );

    assign w_active = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);

    // Priority mem_busy > load_use > branch; branch only flushes when the PC advances.
    always_comb begin
        w_ctrl = ctrl_freeze();
        if (w_active) begin
            if (w_mem_busy) begin
                w_ctrl = ctrl_freeze();
            end else if (w_load_use) begin
                w_ctrl = ctrl_load_use();
            end else begin
                w_ctrl = ctrl_flow(branch_taken);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_bubble_cnt  <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (w_active && !w_ctrl.pc_en) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ctrl.idex_flush && w_ctrl.idex_en) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end

            unique case (r_state)
                ST_RUN: begin
                    if (w_mem_busy) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_busy) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == WAIT_LIMIT) begin
                        r_state       <= ST_HALT;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_en     = w_ctrl.idex_en;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_en    = w_ctrl.exmem_en;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus randomized traffic,
// each cycle's expected outputs queued by the stimulus and checked by a separate monitor.
module tb_hazard_stall_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int WAIT_W   = 4;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       rs_id = '0, rt_id = '0, rd_exe = '0;
    logic             use_rs = 1'b0, use_rt = 1'b0, branch_taken = 1'b0;
    logic             RegWrite_exe = 1'b0, MemWrite_mem = 1'b0, dmem_ready = 1'b1;
    logic [2:0]       MemRead_exe = '0, MemRead_mem = '0;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    hazard_stall_ctrl #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs(use_rs), .use_rt(use_rt),
        .branch_taken(branch_taken), .rd_exe(rd_exe), .RegWrite_exe(RegWrite_exe),
        .MemRead_exe(MemRead_exe), .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic [4:0] rd;
        logic       rw;
        logic [2:0] mre;
        logic [2:0] mrm;
        logic       mw;
        logic       rdy;
    } stim_t;

    // ctl order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush
    typedef struct packed {
        logic [6:0]       ctl;
        logic             tmo;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] bub;
        logic [15:0]      tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: halted flag, count of consecutive busy cycles, counters.
    bit               m_halt;
    int               m_busy_run;
    bit               m_tmo;
    logic [CNT_W-1:0] m_stall, m_bub;

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_halt     = 1'b0;
        m_busy_run = 0;
        m_tmo      = 1'b0;
        m_stall    = '0;
        m_bub      = '0;
    endtask

    task automatic apply(input stim_t s);
        rs_id = s.rs; rt_id = s.rt; use_rs = s.urs; use_rt = s.urt; branch_taken = s.br;
        rd_exe = s.rd; RegWrite_exe = s.rw; MemRead_exe = s.mre; MemRead_mem = s.mrm;
        MemWrite_mem = s.mw; dmem_ready = s.rdy;
    endtask

    task automatic drive(input stim_t s);
        bit   lu, mb;
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        lu = (s.mre != 3'b000) && s.rw && (s.rd != 5'd0) &&
             ((s.urs && s.rd == s.rs) || (s.urt && s.rd == s.rt));
        mb = ((s.mrm != 3'b000) || s.mw) && !s.rdy;
        if (m_halt || mb) e.ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        else if (lu)      e.ctl = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        else              e.ctl = {1'b1, 1'b1, s.br, 1'b1, 1'b0, 1'b1, 1'b0};
        e.tmo   = m_tmo;
        e.stall = m_stall;
        e.bub   = m_bub;
        e.tag   = 16'(cyc);
        cyc++;
        q.push_back(e);
        if (!m_halt) begin
            if (mb) begin
                m_busy_run++;
                m_stall++;
                if (m_busy_run == WAIT_MAX + 1) begin
                    m_halt = 1'b1;
                    m_tmo  = 1'b1;
                end
            end else begin
                m_busy_run = 0;
                if (lu) begin
                    m_stall++;
                    m_bub++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        apply(idle());
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, tag, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ctl", int'(e.tag),
                      64'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}),
                      64'(e.ctl));
                check("mem_timeout", int'(e.tag), 64'(mem_timeout), 64'(e.tmo));
                check("stall_cnt", int'(e.tag), 64'(stall_cnt), 64'(e.stall));
                check("bubble_cnt", int'(e.tag), 64'(bubble_cnt), 64'(e.bub));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        model_reset();
        apply(idle());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(idle());

        // load-use: lw $5 in EXE, ID reads rs=5
        s = idle(); s.mre = 3'b001; s.rw = 1'b1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1'b1;
        drive(s);
        drive(idle());
        // rt match
        s = idle(); s.mre = 3'b010; s.rw = 1'b1; s.rd = 5'd7; s.rt = 5'd7; s.urt = 1'b1;
        drive(s);
        // no stall: rd=0, use_rs=0, plain ALU producer
        s = idle(); s.mre = 3'b001; s.rw = 1'b1; s.rd = 5'd0; s.rs = 5'd0; s.urs = 1'b1;
        drive(s);
        s = idle(); s.mre = 3'b001; s.rw = 1'b1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1'b0;
        drive(s);
        s = idle(); s.mre = 3'b000; s.rw = 1'b1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1'b1;
        drive(s);

        // load in MEM, memory not ready for 3 cycles
        s = idle(); s.mrm = 3'b001; s.rdy = 1'b0;
        repeat (3) drive(s);
        s.rdy = 1'b1;
        drive(s);
        drive(idle());

        // all three hazards at once: freeze only
        s = idle(); s.mw = 1'b1; s.rdy = 1'b0; s.br = 1'b1;
        s.mre = 3'b001; s.rw = 1'b1; s.rd = 5'd3; s.rs = 5'd3; s.urs = 1'b1;
        drive(s);
        drive(s);
        s.rdy = 1'b1;
        drive(s);
        s.mre = 3'b000;
        drive(s);

        // branch only
        s = idle(); s.br = 1'b1;
        drive(s);
        drive(idle());

        // watchdog: memory stuck, then HALT ignores everything
        s = idle(); s.mrm = 3'b100; s.rdy = 1'b0;
        repeat (20) drive(s);
        s = idle(); s.br = 1'b1;
        repeat (3) drive(s);
        do_reset();
        drive(idle());
        s = idle(); s.br = 1'b1;
        drive(s);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            s     = '0;
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.urs = 1'($urandom_range(0, 1));
            s.urt = 1'($urandom_range(0, 1));
            s.br  = ($urandom_range(0, 3) == 0);
            s.rw  = ($urandom_range(0, 3) != 0);
            s.mre = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            s.mrm = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            s.mw  = ($urandom_range(0, 4) == 0);
            s.rdy = (i >= 400 && i < 440) ? 1'b0 : ($urandom_range(0, 9) < 7);
            drive(s);
        end

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
